// File: rtl/captura_pkg.sv
// Shared key codes, FSM state type and key classification for captura_operandos.
package captura_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_BACK  = 4'hC;

  typedef enum logic [1:0] {
    S_OPA,
    S_OPB,
    S_SEND
  } cap_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// 2-FF synchronizer plus rising-edge pulse for the asynchronous key strobe.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic key_evt
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] warm;

  // NOTE: every flop, including the edge-detect history, is reset; a strobe
  // already high at reset release is masked until the history has reloaded,
  // so it never looks like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= 2'd0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign key_evt = s2 & ~s3 & (warm == 2'd3);

endmodule

// File: rtl/captura_operandos.sv
// Assembles two BCD operands from keypad events and hands them off via valid/ready.
// Optional backspace key (0xC) enabled by defining CAPTURA_BACKSPACE_EN.
module captura_operandos
  import captura_pkg::*;
#(
  parameter int NDIG = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_strobe,
  input  logic [3:0]                  key_code,
  output logic [4*NDIG-1:0]           op_a,
  output logic [4*NDIG-1:0]           op_b,
  output logic                        op_valid,
  input  logic                        op_ready,
  output logic [4*NDIG-1:0]           disp_bcd,
  output logic                        sel_b,
  output logic [$clog2(NDIG+1)-1:0]   digit_cnt
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  cap_state_t state;
  logic       key_evt;
  logic       add_digit;
  logic       do_enter;
  logic       do_clear;
  logic       back_hit;

  sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (key_strobe),
    .key_evt  (key_evt)
  );

  // key_code is stable while the strobe is high, so it is read in the event cycle.
  assign add_digit = key_evt && is_digit(key_code) && (digit_cnt < CW'(NDIG))
                     && (state != S_SEND);
  assign do_enter  = key_evt && (key_code == KEY_ENTER);
  assign do_clear  = (key_evt && (key_code == KEY_CLEAR))
                     || ((state == S_SEND) && op_valid && op_ready);

`ifdef CAPTURA_BACKSPACE_EN
  assign back_hit = key_evt && (key_code == KEY_BACK) && (digit_cnt != '0)
                    && (state != S_SEND);
`else
  assign back_hit = 1'b0;
`endif

  assign disp_bcd = sel_b ? op_b : op_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_OPA;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      sel_b     <= 1'b0;
      digit_cnt <= '0;
    end else if (do_clear) begin
      state     <= S_OPA;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      sel_b     <= 1'b0;
      digit_cnt <= '0;
    end else begin
      case (state)
        S_OPA: begin
          if (add_digit) begin
            op_a      <= W'({op_a, key_code});
            digit_cnt <= digit_cnt + CW'(1);
          end else if (do_enter) begin
            state     <= S_OPB;
            sel_b     <= 1'b1;
            digit_cnt <= '0;
          end else if (back_hit) begin
            op_a      <= op_a >> 4;
            digit_cnt <= digit_cnt - CW'(1);
          end
        end
        S_OPB: begin
          if (add_digit) begin
            op_b      <= W'({op_b, key_code});
            digit_cnt <= digit_cnt + CW'(1);
          end else if (do_enter) begin
            state    <= S_SEND;
            op_valid <= 1'b1;
          end else if (back_hit) begin
            op_b      <= op_b >> 4;
            digit_cnt <= digit_cnt - CW'(1);
          end
        end
        S_SEND: ;
        default: state <= S_OPA;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_operandos.sv
// Directed, table-driven bench for captura_operandos (NDIG=3).
module tb_captura_operandos;

  localparam int NDIG = 3;
  localparam int W    = 4 * NDIG;
  localparam int CW   = $clog2(NDIG + 1);

  logic          clk;
  logic          rst;
  logic          key_strobe;
  logic [3:0]    key_code;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_valid;
  logic          op_ready;
  logic [W-1:0]  disp_bcd;
  logic          sel_b;
  logic [CW-1:0] digit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  captura_operandos #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .disp_bcd   (disp_bcd),
    .sel_b      (sel_b),
    .digit_cnt  (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    int           exp_cnt;
    logic         exp_sel;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code   = code;
    key_strobe = 1'b1;
    repeat (4) @(negedge clk);
    key_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    press(vecs[i].code);
    check($sformatf("v%0d op_a", i), 32'(op_a), 32'(vecs[i].exp_a));
    check($sformatf("v%0d op_b", i), 32'(op_b), 32'(vecs[i].exp_b));
    check($sformatf("v%0d digit_cnt", i), 32'(digit_cnt), 32'(vecs[i].exp_cnt));
    check($sformatf("v%0d sel_b", i), 32'(sel_b), 32'(vecs[i].exp_sel));
    check($sformatf("v%0d op_valid", i), 32'(op_valid), 32'(vecs[i].exp_valid));
    check($sformatf("v%0d disp_bcd", i), 32'(disp_bcd),
          32'(vecs[i].exp_sel ? vecs[i].exp_b : vecs[i].exp_a));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcount;
    logic [W-1:0] va, vb;

    vecs[0]  = '{4'h1, 12'h001, 12'h000, 1, 1'b0, 1'b0};
    vecs[1]  = '{4'h2, 12'h012, 12'h000, 2, 1'b0, 1'b0};
    vecs[2]  = '{4'hA, 12'h012, 12'h000, 0, 1'b1, 1'b0};
    vecs[3]  = '{4'h3, 12'h012, 12'h003, 1, 1'b1, 1'b0};
    vecs[4]  = '{4'hA, 12'h012, 12'h003, 1, 1'b1, 1'b1};
    vecs[5]  = '{4'h5, 12'h012, 12'h003, 1, 1'b1, 1'b1};
    vecs[6]  = '{4'hC, 12'h012, 12'h003, 1, 1'b1, 1'b1};
    vecs[7]  = '{4'h9, 12'h009, 12'h000, 1, 1'b0, 1'b0};
    vecs[8]  = '{4'h8, 12'h098, 12'h000, 2, 1'b0, 1'b0};
    vecs[9]  = '{4'h7, 12'h987, 12'h000, 3, 1'b0, 1'b0};
    vecs[10] = '{4'h6, 12'h987, 12'h000, 3, 1'b0, 1'b0};
    vecs[11] = '{4'h4, 12'h987, 12'h000, 3, 1'b0, 1'b0};
    vecs[12] = '{4'hB, 12'h000, 12'h000, 0, 1'b0, 1'b0};
    vecs[13] = '{4'h5, 12'h005, 12'h000, 1, 1'b0, 1'b0};
    vecs[14] = '{4'h6, 12'h056, 12'h000, 2, 1'b0, 1'b0};
`ifdef CAPTURA_BACKSPACE_EN
    vecs[15] = '{4'hC, 12'h005, 12'h000, 1, 1'b0, 1'b0};
    vecs[16] = '{4'hE, 12'h005, 12'h000, 1, 1'b0, 1'b0};
`else
    vecs[15] = '{4'hC, 12'h056, 12'h000, 2, 1'b0, 1'b0};
    vecs[16] = '{4'hE, 12'h056, 12'h000, 2, 1'b0, 1'b0};
`endif
    vecs[17] = '{4'hB, 12'h000, 12'h000, 0, 1'b0, 1'b0};
    vecs[18] = '{4'hC, 12'h000, 12'h000, 0, 1'b0, 1'b0};
    vecs[19] = '{4'hA, 12'h000, 12'h000, 0, 1'b1, 1'b0};
    vecs[20] = '{4'hA, 12'h000, 12'h000, 0, 1'b1, 1'b1};
    vecs[21] = '{4'hB, 12'h000, 12'h000, 0, 1'b0, 1'b0};

    rst        = 1'b1;
    key_strobe = 1'b0;
    key_code   = 4'h0;
    op_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset op_a", 32'(op_a), 32'h0);
    check("reset op_b", 32'(op_b), 32'h0);
    check("reset op_valid", 32'(op_valid), 32'h0);
    check("reset disp_bcd", 32'(disp_bcd), 32'h0);
    check("reset sel_b", 32'(sel_b), 32'h0);
    check("reset digit_cnt", 32'(digit_cnt), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i <= 6; i++) apply_vec(i);

    // Operands stay frozen while op_ready is low
    repeat (5) @(negedge clk);
    check("hold op_valid", 32'(op_valid), 32'h1);
    check("hold op_a", 32'(op_a), 32'h012);
    check("hold op_b", 32'(op_b), 32'h003);

    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("xfer op_valid", 32'(op_valid), 32'h0);
    check("xfer op_a", 32'(op_a), 32'h0);
    check("xfer op_b", 32'(op_b), 32'h0);
    check("xfer sel_b", 32'(sel_b), 32'h0);
    check("xfer digit_cnt", 32'(digit_cnt), 32'h0);
    repeat (3) @(negedge clk);

    for (int i = 7; i <= 21; i++) apply_vec(i);

    // Strobe held high: one digit, appearing on the third rising edge
    @(negedge clk);
    key_code   = 4'h7;
    key_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("hold2 op_a", 32'(op_a), 32'h000);
    @(negedge clk);
    check("hold3 op_a", 32'(op_a), 32'h007);
    check("hold3 digit_cnt", 32'(digit_cnt), 32'h1);
    repeat (47) @(negedge clk);
    key_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check("hold50 op_a", 32'(op_a), 32'h007);
    check("hold50 digit_cnt", 32'(digit_cnt), 32'h1);
    press(4'hB);

    // op_ready high before op_valid: exactly one valid cycle
    op_ready = 1'b1;
    press(4'h1);
    press(4'hA);
    press(4'h2);
    @(negedge clk);
    key_code   = 4'hA;
    key_strobe = 1'b1;
    vcount = 0;
    va = '0;
    vb = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (op_valid) begin
        vcount++;
        va = op_a;
        vb = op_b;
      end
    end
    key_strobe = 1'b0;
    op_ready   = 1'b0;
    repeat (4) @(negedge clk);
    check("early_ready valid cycles", 32'(vcount), 32'd1);
    check("early_ready op_a", 32'(va), 32'h001);
    check("early_ready op_b", 32'(vb), 32'h002);
    check("early_ready after op_a", 32'(op_a), 32'h0);
    check("early_ready after sel_b", 32'(sel_b), 32'h0);

    // Reset mid-handshake with a strobe in flight
    press(4'h3);
    press(4'hA);
    press(4'hA);
    check("pre_rst op_valid", 32'(op_valid), 32'h1);
    @(negedge clk);
    key_code   = 4'h4;
    key_strobe = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst op_valid", 32'(op_valid), 32'h0);
    check("async_rst op_a", 32'(op_a), 32'h0);
    check("async_rst sel_b", 32'(sel_b), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst op_a", 32'(op_a), 32'h0);
    check("post_rst digit_cnt", 32'(digit_cnt), 32'h0);
    key_strobe = 1'b0;
    repeat (4) @(negedge clk);
    press(4'h4);
    check("post_rst press op_a", 32'(op_a), 32'h004);
    check("post_rst press digit_cnt", 32'(digit_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/captura_operandos.md
# captura_operandos

Downstream consumer of the keypad scanner: takes the scanner's latched 4-bit key code plus its key-press strobe, synchronizes and edge-detects the strobe, and assembles two BCD operands of `NDIG` digits. The operands are handed to the adder stage through a valid/ready handshake. The block also drives the BCD value of the operand currently being typed, for the 7-segment display path.

## Interface
Parameters:
- `NDIG`, default 3: BCD digits per operand (≥1).

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `key_strobe`  in  1: key-pressed level from the scanner; asynchronous to `clk`.
- `key_code`  in  4: latched key code; stable while `key_strobe` is high.
- `op_a`  out  4*NDIG: operand A, BCD, most-significant digit in the top nibble.
- `op_b`  out  4*NDIG: operand B, BCD.
- `op_valid`  out  1: A and B are complete and held stable.
- `op_ready`  in  1: adder accepts the operands.
- `disp_bcd`  out  4*NDIG: operand shown on the display.
- `sel_b`  out  1: high while operand B is being entered or sent.
- `digit_cnt`  out  $clog2(NDIG+1): number of digits in the current operand.

## Operation
- The strobe passes through a 2-FF synchronizer and a rising-edge detector. This produces a one-cycle `key_evt`. `key_code` is sampled in the same cycle as `key_evt`.
- Key classes:
  - 0x0–0x9: digit.
  - 0xA: ENTER.
  - 0xB: CLEAR.
  - 0xC: BACKSPACE (see Configuration).
  - 0xD–0xF: ignored.
- FSM states and transitions:
  - **S_OPA**:
    - digit: if `digit_cnt < NDIG`, `op_a <= {op_a[4*NDIG-5:0], code}` and `digit_cnt++`. Otherwise the digit is ignored.
    - ENTER: go to S_OPB with `digit_cnt <= 0`. This is allowed with 0 digits; the operand value is then 0.
  - **S_OPB**:
    - digit: same rule as S_OPA, applied to `op_b`.
    - ENTER: go to S_SEND.
  - **S_SEND**:
    - `op_valid=1`. All keys are ignored except CLEAR.
    - When `op_valid & op_ready` is sampled high, go to S_OPA. On that same edge, clear `op_a`, `op_b` and `digit_cnt` to 0.
- CLEAR in any state: go to S_OPA and zero `op_a`, `op_b` and `digit_cnt`. CLEAR in S_SEND drops `op_valid` without a transfer.
- `disp_bcd`: equals `op_a` in S_OPA and `op_b` in S_OPB/S_SEND.
- `sel_b`: 1 in S_OPB/S_SEND.
- `digit_cnt`: counts digits of the operand currently displayed.
- Operands are BCD only; no binary conversion happens in this block.

## Timing
- Reset values: `op_a=0`, `op_b=0`, `op_valid=0`, `disp_bcd=0`, `sel_b=0`, `digit_cnt=0`, state S_OPA, synchronizer flops 0.
- Latency from `key_strobe` rising to the register update is at most 3 `clk` edges: 2 synchronizer edges, 1 edge-detect/update edge.
- `key_strobe` must stay high ≥3 cycles and low ≥3 cycles. A strobe held high produces exactly one event.
- `op_valid` rises on the edge after the ENTER event in S_OPB. It stays high, with `op_a`/`op_b` frozen, until the handshake edge. It falls on the cycle after that edge.
- `op_ready` may be high before `op_valid`; the transfer then completes on the first cycle `op_valid` is high.
- Asserting `rst` mid-entry or mid-handshake immediately forces all reset values. Any in-flight strobe is lost. A strobe still high when reset is released does not generate an event, because the edge detector reloads from the synchronizer.

## Configuration
- `CAPTURA_BACKSPACE_EN` defined:
  - In S_OPA/S_OPB, key 0xC with `digit_cnt>0` shifts the current operand right one nibble, zero-filling the top, and decrements `digit_cnt`.
  - With `digit_cnt=0`, 0xC is a no-op.
  - 0xC is ignored in S_SEND.
- `CAPTURA_BACKSPACE_EN` undefined: 0xC is treated like 0xD–0xF (ignored).

## Structure
- Package `captura_pkg`:
  - Key-code constants: `KEY_ENTER=4'hA`, `KEY_CLEAR=4'hB`, `KEY_BACK=4'hC`.
  - State enum `cap_state_t` {S_OPA, S_OPB, S_SEND}.
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge pulse. It has `clk`/`rst`, a 1-bit async input and the `key_evt` output.

## Test plan
- Reset, then key strobes 1, 2, ENTER, 3, ENTER with `op_ready=0` → `op_a=12'h012`, `op_b=12'h003`, `op_valid=1` held, `sel_b=1`.
- From that state, assert `op_ready` for 1 cycle → transfer on that edge. Next cycle: `op_valid=0`, `op_a=op_b=0`, `sel_b=0`.
- With NDIG=3, keys 9,8,7,6 → `op_a=12'h987` and `digit_cnt=3`; the fourth digit is ignored.
- Keys 4, 5, CLEAR → `op_a=0`, `digit_cnt=0`, state S_OPA.
- Hold `key_strobe` high for 50 cycles with code 0x7 → exactly one digit appended, 3 edges after the rise. Key 0xE → no change.
- With `CAPTURA_BACKSPACE_EN`: keys 5,6, 0xC → `op_a=12'h005`, `digit_cnt=1`. Without the macro the same sequence leaves `op_a=12'h056`.
